// File: rtl/svo_openldi_rx_if.sv
// Deserializer lane words in, decoded SVO video and link status out.
interface svo_openldi_rx_if;
  logic [6:0] in_c;
  logic [6:0] in_a0;
  logic [6:0] in_a1;
  logic [6:0] in_a2;
  logic [6:0] in_a3;
  logic       de;
  logic       vs;
  logic       hs;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       locked;
  logic [2:0] offset;
  logic [7:0] err_count;

  modport master (
    output in_c, in_a0, in_a1, in_a2, in_a3,
    input  de, vs, hs, r, g, b, locked, offset, err_count
  );

  modport slave (
    input  in_c, in_a0, in_a1, in_a2, in_a3,
    output de, vs, hs, r, g, b, locked, offset, err_count
  );
endinterface

// File: rtl/svo_openldi_rx.sv
// OpenLDI receive: recovers word alignment from the clock lane and decodes
// the four data lanes back into r/g/b plus de/vs/hs.
module svo_openldi_rx #(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 3
) (
  input  logic            clk,
  input  logic            resetn,
  svo_openldi_rx_if.slave bus
);
  localparam int unsigned WORD_W  = 7;
  localparam int unsigned LANES   = 5;
  localparam int unsigned OFF_W   = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ERR_W   = 8;
  localparam int unsigned VIDEO_W = 27;

  localparam logic [WORD_W-1:0] CLK_PATTERN   = 7'b1100011;
  localparam logic [OFF_W-1:0]  OFF_LAST      = 3'd6;
  localparam logic [ERR_W-1:0]  ERR_MAX       = 8'hFF;
  localparam logic [CNT_W-1:0]  LOCK_TARGET   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]  UNLOCK_TARGET = CNT_W'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [OFF_W-1:0]             offset_q, offset_d, offset_inc;
  logic [CNT_W-1:0]             match_q, match_d, match_inc;
  logic [CNT_W-1:0]             miss_q, miss_d, miss_inc;
  logic [ERR_W-1:0]             err_q, err_d;
  logic                         locked_q;
  logic [VIDEO_W-1:0]           video_q, video_d;
  logic [LANES-1:0][WORD_W-1:0] cur, prev_q, aligned;
  logic                         clk_match;

  // Lane 0 is the clock lane, lanes 1..4 are a0..a3.
  assign cur = {bus.in_a3, bus.in_a2, bus.in_a1, bus.in_a0, bus.in_c};

  // Offset k picks bits [13-k:7-k] of {prev, cur}.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      aligned[i] = WORD_W'({prev_q[i], cur[i]} >> (4'd7 - {1'b0, offset_q}));
    end
  end

  assign clk_match  = (aligned[0] == CLK_PATTERN);
  assign offset_inc = (offset_q == OFF_LAST) ? '0 : offset_q + OFF_W'(1);
  assign match_inc  = match_q + CNT_W'(1);
  assign miss_inc   = miss_q + CNT_W'(1);

  // Alignment search / verify / lock tracking.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    match_d  = match_q;
    miss_d   = miss_q;
    err_d    = err_q;
    case (state_q)
      SEARCH: begin
        if (clk_match) begin
          match_d = CNT_W'(1);
          state_d = (LOCK_TARGET == CNT_W'(1)) ? LOCKED : VERIFY;
        end else begin
          offset_d = offset_inc;
        end
      end
      VERIFY: begin
        if (clk_match) begin
          match_d = match_inc;
          if (match_inc == LOCK_TARGET) begin
            state_d = LOCKED;
          end
        end else begin
          state_d  = SEARCH;
          match_d  = '0;
          offset_d = offset_inc;
        end
      end
      LOCKED: begin
        if (clk_match) begin
          miss_d = '0;
        end else begin
          miss_d = miss_inc;
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          if (miss_inc == UNLOCK_TARGET) begin
            state_d  = SEARCH;
            miss_d   = '0;
            match_d  = '0;
            offset_d = offset_inc;
          end
        end
      end
      default: begin
        state_d  = SEARCH;
        offset_d = '0;
        match_d  = '0;
        miss_d   = '0;
      end
    endcase
  end

  // Decode {de, vs, hs, r, g, b}; gated by the pre-edge state.
  always_comb begin
    video_d = '0;
    if (state_q == LOCKED) begin
      video_d = {aligned[3][6], aligned[3][5], aligned[3][4],
                 aligned[4][1:0], aligned[1][5:0],
                 aligned[4][3:2], aligned[2][4:0], aligned[1][6],
                 aligned[4][5:4], aligned[3][3:0], aligned[2][6:5]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= SEARCH;
      offset_q <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
      video_q  <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
      video_q  <= video_d;
      prev_q   <= cur;
    end
  end

  assign {bus.de, bus.vs, bus.hs, bus.r, bus.g, bus.b} = video_q;
  assign bus.locked    = locked_q;
  assign bus.offset    = offset_q;
  assign bus.err_count = err_q;
endmodule

// File: doc/svo_openldi_rx.md
Name: svo_openldi_rx

Overview:
- Receive-side counterpart of the SVO OpenLDI lane encoder.
- Takes raw 7-bit parallel words per lane from an external 7:1 deserializer, whose word boundary is arbitrary.
- Recovers word alignment from the clock lane, then decodes the four data lanes back to 8-bit r/g/b plus de/vs/hs.
- Sits between the deserializer and downstream SVO video consumers (capture, monitor, loopback checking).

Parameters:
- LOCK_COUNT, 4: consecutive clock-pattern matches needed to enter LOCKED (range 1..15).
- UNLOCK_COUNT, 3: consecutive clock-pattern mismatches in LOCKED that drop back to SEARCH (range 1..15).

Ports:
- clk  input  1  pixel clock; one lane word per lane per cycle.
- resetn  input  1  asynchronous active-low reset.
- in_c  input  7  clock-lane raw word; bit 6 is first-received.
- in_a0, in_a1, in_a2, in_a3  input  7 each  data-lane raw words; same bit order as in_c.
- de, vs, hs  output  1 each  decoded sync/enable.
- r, g, b  output  8 each  decoded colour.
- locked  output  1  high in LOCKED state.
- offset  output  3  current alignment offset, 0..6.
- err_count  output  8  saturating count of clock mismatches seen while LOCKED.

Behaviour:
- Registered history:
  - prev_c and prev_a0..prev_a3 capture the in_* words every cycle.
  - Reset value: 0.
- Alignment window:
  - Per lane, form w = {prev, cur} (14 bits).
  - Aligned word at offset k is w[13-k : 7-k].
  - k=0 selects prev unchanged; k=6 selects prev[0] followed by cur[6:1].
- Clock check: match when the aligned clock word equals 7'b1100011.
- States: SEARCH, VERIFY, LOCKED. Reset state is SEARCH, offset=0, counters=0.
- SEARCH:
  - Mismatch: offset advances by 1, wrapping 6->0.
  - Match: go to VERIFY with match_cnt=1; offset unchanged.
  - If LOCK_COUNT=1, a match goes directly to LOCKED.
- VERIFY:
  - Match: match_cnt increments. Reaching LOCK_COUNT enters LOCKED.
  - Mismatch: return to SEARCH and advance offset (wrapping).
- LOCKED:
  - Offset is frozen.
  - Match: miss_cnt is cleared.
  - Mismatch: miss_cnt increments and err_count increments, saturating at 255.
  - When miss_cnt reaches UNLOCK_COUNT: go to SEARCH, clear miss_cnt, advance offset.
- locked is registered. It is high exactly while the state register is LOCKED.
- offset output is the offset register.
- Decode, applied to the aligned words a0..a3:
  - r = {a3[1], a3[0], a0[5:0]}
  - g = {a3[3], a3[2], a1[4:0], a0[6]}
  - b = {a3[5], a3[4], a2[3:0], a1[6:5]}
  - hs = a2[4], vs = a2[5], de = a2[6]
  - a3[6] is reserved and ignored.
- Output register, latency and gating:
  - de/vs/hs/r/g/b are registered.
  - At each clk edge they load the decode of the aligned words formed from the current in_* and prev_*.
  - Latency is 1 cycle from in_* to outputs.
  - The load is gated by the state value before that edge:
    - If the state is not LOCKED, all six load 0.
    - The cycle entering LOCKED therefore still outputs 0.
- Simultaneous events: the state transition and output load use the same pre-edge state and offset. There is no same-cycle bypass.
- resetn assertion at any time (including mid-lock or mid-frame):
  - Asynchronously clears all outputs, history, counters, err_count and offset.
  - Forces SEARCH.
  - Operation resumes on the first clk edge after deassertion.
- err_count is cleared only by reset.

Test Plan:
- Aligned stream:
  - Stimulus: in_c=7'b1100011 every cycle, data lanes encoding r=8'hA5 g=8'h3C b=8'hF0 de=1 vs=0 hs=1.
  - Required: locked rises after 4 matching cycles with offset=0. Thereafter r=A5 g=3C b=F0 de=1 hs=1 vs=0, 1 cycle after input. Before lock all outputs are 0.
- Misaligned stream:
  - Stimulus: the same stream rotated so the correct offset is 3.
  - Required: offset steps 0,1,2,3 and stops; locked asserts LOCK_COUNT cycles later; decoded pixels match the source values.
- Wrap-around:
  - Stimulus: correct offset 0, but the search starts from offset 1 after an induced unlock.
  - Required: offset steps through 2..6, wraps to 0, then locks.
- Lock loss:
  - Stimulus: while locked, corrupt in_c for 2 cycles, then 3 cycles.
  - Required: for 2 cycles, locked stays high, err_count=2 and offset holds. For 3 cycles, err_count=5, locked drops after the third mismatch, outputs go to 0, and the search restarts at offset+1.
- Saturation:
  - Stimulus: 300 isolated single-cycle clock errors while locked.
  - Required: err_count=255 and locked remains high.
- Reset mid-operation:
  - Stimulus: assert resetn low asynchronously (mid-cycle) while locked with de=1.
  - Required: immediately de=vs=hs=0, r=g=b=0, locked=0, offset=0, err_count=0. After release, relock takes LOCK_COUNT+offset cycles.
